pid_axis_scheduler: RTL and testbench
=====================================

# pid_axis_scheduler

Sequencer for the two-axis position PID datapath. Generates each axis's 20 kHz sample enable, phase-staggered, from the 100 MHz clock. Applies software gain updates atomically on sample boundaries through shadow registers. Runs a per-axis enable/fault state machine that gates sampling and latches a fault when an axis's control output stays saturated.

## Interface
Parameters:
- DIVIDER, 5000: clk cycles per sample period (100 MHz / 20 kHz).
- PHASE_OFFSET, 2500: counter value of axis-1 tick; must be in 1..DIVIDER-1.
- SAT_LEVEL, 3950: saturation threshold on |control signal|.
- SAT_LIMIT, 2000: consecutive saturated samples that trigger a fault (100 ms).
- KP_INIT, 16'h0100: reset value of active Kp, both axes (Q8.8 = 1.0).
- KI_INIT, 16'h0000: reset value of active Ki.
- KD_INIT, 16'h0000: reset value of active Kd.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high reset.
- axis_en_req  in  2  per-axis run request (level).
- fault_clr  in  2  per-axis fault clear (pulse).
- gain_wr  in  1  staging write strobe.
- gain_axis  in  1  axis for gain_wr.
- gain_sel  in  2  0=Kp, 1=Ki, 2=Kd, 3=ignored.
- gain_data  in  16  gain value, Q8.8.
- gain_commit  in  1  commit strobe.
- gain_commit_axis  in  1  axis for gain_commit.
- ctrl_sig0, ctrl_sig1  in  16 signed  PID control outputs per axis.
- sample_en  out  2  one-cycle sample enable per axis.
- axis_run  out  2  axis in RUN state.
- axis_fault  out  2  axis in FAULT state.
- kp0, ki0, kd0, kp1, ki1, kd1  out  16  active gains.
- commit_pending  out  2  staged gains waiting for the next tick.

## Operation
- Free-running counter: 0..DIVIDER-1, wraps to 0. Internal tick0 fires at count 0; tick1 fires at count PHASE_OFFSET. Ticks run in every state.
- Staging: six 16-bit staging registers, reset to the *_INIT values.
  - gain_wr writes staging[gain_axis][gain_sel].
  - gain_sel=3 writes nothing.
- Commit:
  - gain_commit sets commit_pending[gain_commit_axis].
  - On tickN with pendingN=1: active gains of axis N <= staging of axis N, all three at once, and pendingN clears.
  - Commit and tickN in the same cycle: the current pendingN is honoured, and pendingN stays 1 for the next tick (set wins over clear).
  - gain_wr coincident with the applying tick: the active copy takes the pre-write staging value; the write lands in staging only.
- Per-axis FSM, states DISABLED, RUN, FAULT:
  - DISABLED -> RUN: on tickN with axis_en_req[N]=1. Clears sat_cnt.
  - RUN -> DISABLED: on any cycle with axis_en_req[N]=0.
  - RUN -> FAULT: on tickN when the saturated sample would make sat_cnt reach SAT_LIMIT.
  - FAULT -> DISABLED: on fault_clr[N]=1 with axis_en_req[N]=0. fault_clr is ignored while the request is high, so there is no auto-restart.
- Saturation counter, 16-bit, saturating, updated only on tickN in RUN:
  - ctrl_sigN >= SAT_LEVEL or ctrl_sigN <= -SAT_LEVEL: increment.
  - Otherwise: clear to 0.
  - Comparisons are signed; -32768 counts as saturated.
- Outputs: axis_run and axis_fault are decoded from registered state. sample_en[N] = registered (tickN AND next-state RUN). The first sample_en is therefore issued on the tick that enters RUN.
- Axes are fully independent; both may fault, commit or run at the same time.

## Timing
- Values after reset:
  - counter=0, all FSMs DISABLED.
  - sample_en=0, axis_run=0, axis_fault=0, commit_pending=0.
  - Active and staged gains = *_INIT.
- The counter reads 0 in the first cycle after reset deasserts, so tick0 fires in that cycle.
- sample_en[N] rises exactly 1 cycle after the tickN cycle and stays high for 1 cycle. New gains are visible in the same cycle as that sample_en.
- Period: sample_en[0] every DIVIDER cycles. sample_en[1] lags sample_en[0] by PHASE_OFFSET cycles.
- axis_run falls 1 cycle after axis_en_req falls. No further sample_en is issued after that, including a tick in the same cycle.
- axis_fault rises, and axis_run falls, 1 cycle after the faulting tick.
- Reset asserted mid-operation: everything returns to reset values at the next edge. Pending commits and staged writes are discarded.

## Test plan
- Reset release with axis_en_req=2'b11 → sample_en[0] pulses at cycles 1, 5001, 10001 and sample_en[1] at cycles 2501, 7501; each pulse 1 cycle wide. axis_run=11 from cycle 1 (axis 0) and cycle 2501 (axis 1).
- Write axis 0 Kp=16'h0280 and Ki=16'h0010, commit mid-period → kp0/ki0 unchanged until the next tick0. Both change in the cycle sample_en[0] is high. commit_pending[0] 1→0; axis 1 gains unchanged.
- Axis 1 running, ctrl_sig1=4000 held → axis_fault[1]=1 and axis_run[1]=0 after the 2000th tick1. sample_en[1] stops. With ctrl_sig1=3949 on sample 1999, no fault occurs and the count restarts.
- In FAULT, fault_clr[1] pulse with axis_en_req[1]=1 → remains FAULT. Drop the request, pulse fault_clr → DISABLED. Re-raise the request → RUN at the next tick1.
- gain_commit coincident with tick0 while pending=1, plus gain_wr Kd=5 in the same cycle → old staging applied now, pending stays 1. Kd=5 becomes active on the following tick0.
- Reset pulse during RUN with a pending commit → all outputs return to reset values next cycle. Gains equal KP_INIT/KI_INIT/KD_INIT and pending=0.

Source files
------------

// File: rtl/pid_axis_scheduler.sv
// Two-axis PID sequencer: phase-staggered sample ticks, shadowed gain commits,
// and per-axis DISABLED/RUN/FAULT control with saturation-fault detection.
module pid_axis_scheduler #(
  parameter int          DIVIDER      = 5000,
  parameter int          PHASE_OFFSET = 2500,
  parameter int          SAT_LEVEL    = 3950,
  parameter int          SAT_LIMIT    = 2000,
  parameter logic [15:0] KP_INIT      = 16'h0100,
  parameter logic [15:0] KI_INIT      = 16'h0000,
  parameter logic [15:0] KD_INIT      = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         axis_en_req,
  input  logic [1:0]         fault_clr,
  input  logic               gain_wr,
  input  logic               gain_axis,
  input  logic [1:0]         gain_sel,
  input  logic [15:0]        gain_data,
  input  logic               gain_commit,
  input  logic               gain_commit_axis,
  input  logic signed [15:0] ctrl_sig0,
  input  logic signed [15:0] ctrl_sig1,
  output logic [1:0]         sample_en,
  output logic [1:0]         axis_run,
  output logic [1:0]         axis_fault,
  output logic [15:0]        kp0,
  output logic [15:0]        ki0,
  output logic [15:0]        kd0,
  output logic [15:0]        kp1,
  output logic [15:0]        ki1,
  output logic [15:0]        kd1,
  output logic [1:0]         commit_pending
);

  localparam int                CW      = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic signed [16:0] SAT_POS = 17'(SAT_LEVEL);
  localparam logic signed [16:0] SAT_NEG = 17'(-SAT_LEVEL);
  localparam logic [16:0]        SAT_LIM = 17'(SAT_LIMIT);

  typedef enum logic [1:0] {ST_DISABLED, ST_RUN, ST_FAULT} state_t;

  logic [CW-1:0]      cnt;
  logic [1:0]         tick;
  logic [1:0]         sat;
  logic [1:0]         sat_hit;
  logic [1:0]         commit_set;
  logic signed [15:0] ctrl    [2];
  logic [15:0]        sat_cnt [2];
  logic [15:0]        stg     [2][3];
  logic [15:0]        act     [2][3];
  state_t             state    [2];
  state_t             state_nx [2];

  assign tick[0] = (cnt == '0);
  assign tick[1] = (cnt == CW'(PHASE_OFFSET));
  assign ctrl[0] = ctrl_sig0;
  assign ctrl[1] = ctrl_sig1;

  assign kp0 = act[0][0];
  assign ki0 = act[0][1];
  assign kd0 = act[0][2];
  assign kp1 = act[1][0];
  assign ki1 = act[1][1];
  assign kd1 = act[1][2];

  // Request-low exit takes priority over a fault on the same tick.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      sat[i]        = ($signed({ctrl[i][15], ctrl[i]}) >= SAT_POS) ||
                      ($signed({ctrl[i][15], ctrl[i]}) <= SAT_NEG);
      sat_hit[i]    = sat[i] && (({1'b0, sat_cnt[i]} + 17'd1) >= SAT_LIM);
      commit_set[i] = gain_commit && (gain_commit_axis == 1'(i));
      state_nx[i]   = state[i];
      case (state[i])
        ST_DISABLED: if (tick[i] && axis_en_req[i]) state_nx[i] = ST_RUN;
        ST_RUN: begin
          if (!axis_en_req[i])           state_nx[i] = ST_DISABLED;
          else if (tick[i] && sat_hit[i]) state_nx[i] = ST_FAULT;
        end
        ST_FAULT: if (fault_clr[i] && !axis_en_req[i]) state_nx[i] = ST_DISABLED;
        default: state_nx[i] = ST_DISABLED;
      endcase
      axis_run[i]   = (state[i] == ST_RUN);
      axis_fault[i] = (state[i] == ST_FAULT);
    end
  end

  // Nonblocking updates let the applying tick copy pre-write staging values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt            <= '0;
      sample_en      <= '0;
      commit_pending <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        state[i]   <= ST_DISABLED;
        sat_cnt[i] <= '0;
        stg[i][0]  <= KP_INIT;
        stg[i][1]  <= KI_INIT;
        stg[i][2]  <= KD_INIT;
        act[i][0]  <= KP_INIT;
        act[i][1]  <= KI_INIT;
        act[i][2]  <= KD_INIT;
      end
    end else begin
      cnt <= (cnt == CW'(DIVIDER - 1)) ? '0 : cnt + CW'(1);
      for (int unsigned i = 0; i < 2; i++) begin
        state[i]     <= state_nx[i];
        sample_en[i] <= tick[i] && (state_nx[i] == ST_RUN);
        if (state[i] == ST_DISABLED && state_nx[i] == ST_RUN)
          sat_cnt[i] <= '0;
        else if (state[i] == ST_RUN && tick[i])
          sat_cnt[i] <= !sat[i] ? '0 : ((&sat_cnt[i]) ? sat_cnt[i] : sat_cnt[i] + 16'd1);
        if (tick[i] && commit_pending[i])
          for (int unsigned j = 0; j < 3; j++) act[i][j] <= stg[i][j];
        if (commit_set[i])
          commit_pending[i] <= 1'b1;
        else if (tick[i])
          commit_pending[i] <= 1'b0;
      end
      if (gain_wr) begin
        case (gain_sel)
          2'd0:    stg[gain_axis][0] <= gain_data;
          2'd1:    stg[gain_axis][1] <= gain_data;
          2'd2:    stg[gain_axis][2] <= gain_data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pid_axis_scheduler.sv
// Self-checking bench for pid_axis_scheduler using a shortened sample period
// so that saturation faults and multi-period sequences stay short.
module tb_pid_axis_scheduler;

  localparam int D   = 40;
  localparam int PO  = 15;
  localparam int SL  = 3950;
  localparam int LIM = 6;
  localparam logic [0:5][15:0] GI = {16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000};

  logic               clk = 1'b0;
  logic               reset;
  logic [1:0]         axis_en_req, fault_clr;
  logic               gain_wr, gain_axis, gain_commit, gain_commit_axis;
  logic [1:0]         gain_sel;
  logic [15:0]        gain_data;
  logic signed [15:0] ctrl_sig0, ctrl_sig1;
  logic [1:0]         sample_en, axis_run, axis_fault, commit_pending;
  logic [15:0]        kp0, ki0, kd0, kp1, ki1, kd1;
  logic [0:5][15:0]   gains;

  assign gains = {kp0, ki0, kd0, kp1, ki1, kd1};

  pid_axis_scheduler #(
    .DIVIDER(D), .PHASE_OFFSET(PO), .SAT_LEVEL(SL), .SAT_LIMIT(LIM),
    .KP_INIT(16'h0100), .KI_INIT(16'h0000), .KD_INIT(16'h0000)
  ) dut (
    .clk(clk), .reset(reset), .axis_en_req(axis_en_req), .fault_clr(fault_clr),
    .gain_wr(gain_wr), .gain_axis(gain_axis), .gain_sel(gain_sel), .gain_data(gain_data),
    .gain_commit(gain_commit), .gain_commit_axis(gain_commit_axis),
    .ctrl_sig0(ctrl_sig0), .ctrl_sig1(ctrl_sig1),
    .sample_en(sample_en), .axis_run(axis_run), .axis_fault(axis_fault),
    .kp0(kp0), .ki0(ki0), .kd0(kd0), .kp1(kp1), .ki1(ki1), .kd1(kd1),
    .commit_pending(commit_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         rel;
    logic [1:0] se;
  } ev_t;

  typedef struct {
    logic             ax;
    logic [1:0]       sel;
    logic [15:0]      data;
    logic             commit;
    logic [0:5][15:0] g;
  } vec_t;

  ev_t  sb [$];
  vec_t tbl [8];
  int   checks = 0, errors = 0;
  int   cyc = 0, base = 0;

  logic signed [15:0] v1 [5] = '{16'sd4000, 16'sd3950, -16'sd3950, 16'sh8000, 16'sd4000};
  logic signed [15:0] v2 [6] = '{16'sh8000, 16'sd32767, 16'sd3950, -16'sd4000, -16'sd3950, 16'sd4000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int phase();
    return (cyc - base) % D;
  endfunction

  task automatic goto_phase(input int p);
    for (int k = 0; k < D && phase() != p; k++) step();
  endtask

  task automatic wait_se(input int ax, input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (!sample_en[ax] && n < D + 2);
    check(name, 32'(sample_en[ax]), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_se"},    32'(sample_en), 32'd0);
    check({tag, "_run"},   32'(axis_run), 32'd0);
    check({tag, "_fault"}, 32'(axis_fault), 32'd0);
    check({tag, "_pend"},  32'(commit_pending), 32'd0);
    for (int i = 0; i < 6; i++)
      check($sformatf("%s_gain%0d", tag, i), 32'(gains[i]), 32'(GI[i]));
  endtask

  task automatic write_gain(input logic ax, input logic [1:0] sel, input logic [15:0] d);
    gain_wr = 1'b1; gain_axis = ax; gain_sel = sel; gain_data = d;
    step();
    gain_wr = 1'b0;
  endtask

  task automatic commit(input logic ax);
    gain_commit = 1'b1; gain_commit_axis = ax;
    step();
    gain_commit = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    ev_t        e;
    logic [1:0] exp_se;
    bit         ok;
    int         n;

    tbl[0] = '{1'b0, 2'd0, 16'h0280, 1'b0, {16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000}};
    tbl[1] = '{1'b0, 2'd1, 16'h0010, 1'b1, {16'h0280, 16'h0010, 16'h0000, 16'h0100, 16'h0000, 16'h0000}};
    tbl[2] = '{1'b1, 2'd2, 16'h1234, 1'b1, {16'h0280, 16'h0010, 16'h0000, 16'h0100, 16'h0000, 16'h1234}};
    tbl[3] = '{1'b1, 2'd3, 16'hFFFF, 1'b1, {16'h0280, 16'h0010, 16'h0000, 16'h0100, 16'h0000, 16'h1234}};
    tbl[4] = '{1'b0, 2'd2, 16'h0005, 1'b1, {16'h0280, 16'h0010, 16'h0005, 16'h0100, 16'h0000, 16'h1234}};
    tbl[5] = '{1'b1, 2'd0, 16'h0300, 1'b1, {16'h0280, 16'h0010, 16'h0005, 16'h0300, 16'h0000, 16'h1234}};
    tbl[6] = '{1'b0, 2'd0, 16'h0000, 1'b0, {16'h0280, 16'h0010, 16'h0005, 16'h0300, 16'h0000, 16'h1234}};
    tbl[7] = '{1'b1, 2'd1, 16'h0042, 1'b1, {16'h0280, 16'h0010, 16'h0005, 16'h0300, 16'h0042, 16'h1234}};

    reset = 1'b1; axis_en_req = 2'b11; fault_clr = 2'b00;
    gain_wr = 1'b0; gain_axis = 1'b0; gain_sel = 2'd0; gain_data = '0;
    gain_commit = 1'b0; gain_commit_axis = 1'b0;
    ctrl_sig0 = '0; ctrl_sig1 = '0;
    step();
    step();
    check_reset_state("rst0");
    reset = 1'b0;
    base  = cyc;

    // Sample schedule from reset release, via expected-event queue
    for (int p = 0; p < 3; p++) begin
      sb.push_back('{p * D + 1, 2'b01});
      sb.push_back('{p * D + PO + 1, 2'b10});
    end
    for (int r = 1; r <= 3 * D; r++) begin
      step();
      exp_se = 2'b00;
      if (sb.size() > 0 && sb[0].rel == r) begin
        e = sb.pop_front();
        exp_se = e.se;
      end
      check($sformatf("sched_se_c%0d", r), 32'(sample_en), 32'(exp_se));
      check($sformatf("sched_run_c%0d", r), 32'(axis_run), {30'd0, (r >= PO + 1), 1'b1});
    end
    check("sched_queue_empty", 32'(sb.size()), 32'd0);

    // Mid-period commit becomes visible with the next sample_en[0]
    goto_phase(10);
    write_gain(1'b0, 2'd0, 16'h0280);
    write_gain(1'b0, 2'd1, 16'h0010);
    commit(1'b0);
    check("commit_pend_set", 32'(commit_pending), 32'h1);
    ok = 1'b1;
    n  = 0;
    while (!sample_en[0] && n < 2 * D) begin
      if (kp0 !== 16'h0100 || ki0 !== 16'h0000 || commit_pending[0] !== 1'b1) ok = 1'b0;
      step();
      n++;
    end
    check("commit_held_until_tick", 32'(ok), 32'd1);
    check("commit_se0_seen", 32'(sample_en[0]), 32'd1);
    check("commit_phase", 32'(phase()), 32'd1);
    check("commit_kp0", 32'(kp0), 32'h0280);
    check("commit_ki0", 32'(ki0), 32'h0010);
    check("commit_pend_clr", 32'(commit_pending[0]), 32'd0);
    check("commit_kp1_untouched", 32'(kp1), 32'h0100);
    check("commit_ki1_untouched", 32'(ki1), 32'h0000);

    // Request drop on the tick0 cycle suppresses that sample
    goto_phase(0);
    axis_en_req[0] = 1'b0;
    step();
    check("drop_se0", 32'(sample_en[0]), 32'd0);
    check("drop_run0", 32'(axis_run[0]), 32'd0);
    axis_en_req[0] = 1'b1;

    // Saturation: five saturated then 3949 (no fault), then six saturated -> fault
    wait_se(1, "sat_sync");
    for (int k = 0; k < 5; k++) begin
      ctrl_sig1 = v1[k];
      wait_se(1, $sformatf("sat_a_se%0d", k));
      check($sformatf("sat_a_nofault%0d", k), 32'(axis_fault[1]), 32'd0);
    end
    ctrl_sig1 = 16'sd3949;
    wait_se(1, "sat_3949_se");
    check("sat_3949_nofault", 32'(axis_fault[1]), 32'd0);
    check("sat_3949_run", 32'(axis_run[1]), 32'd1);
    for (int k = 0; k < 5; k++) begin
      ctrl_sig1 = v2[k];
      wait_se(1, $sformatf("sat_b_se%0d", k));
      check($sformatf("sat_b_nofault%0d", k), 32'(axis_fault[1]), 32'd0);
    end
    ctrl_sig1 = v2[5];
    n = 0;
    do begin
      step();
      n++;
    end while (!axis_fault[1] && n < D + 2);
    check("fault_set", 32'(axis_fault[1]), 32'd1);
    check("fault_latency", 32'(n), 32'(D));
    check("fault_run_low", 32'(axis_run[1]), 32'd0);
    check("fault_se_low", 32'(sample_en[1]), 32'd0);
    ok = 1'b1;
    for (int k = 0; k < D; k++) begin
      step();
      if (sample_en[1] !== 1'b0 || axis_fault[1] !== 1'b1) ok = 1'b0;
    end
    check("fault_no_samples", 32'(ok), 32'd1);

    // Fault clear only honoured with the request low
    fault_clr = 2'b10;
    step();
    fault_clr = 2'b00;
    check("clr_ignored_req_high", 32'(axis_fault[1]), 32'd1);
    axis_en_req[1] = 1'b0;
    step();
    check("fault_holds_req_low", 32'(axis_fault[1]), 32'd1);
    fault_clr = 2'b10;
    step();
    fault_clr = 2'b00;
    check("clr_fault_low", 32'(axis_fault[1]), 32'd0);
    check("clr_run_low", 32'(axis_run[1]), 32'd0);
    ctrl_sig1 = '0;
    axis_en_req[1] = 1'b1;
    wait_se(1, "rerun_se1");
    check("rerun_run1", 32'(axis_run[1]), 32'd1);
    check("rerun_phase", 32'(phase()), 32'(PO + 1));

    // Commit and Kd write coincident with tick0 while already pending
    goto_phase(10);
    write_gain(1'b0, 2'd2, 16'h0033);
    commit(1'b0);
    goto_phase(0);
    gain_wr = 1'b1; gain_axis = 1'b0; gain_sel = 2'd2; gain_data = 16'h0005;
    gain_commit = 1'b1; gain_commit_axis = 1'b0;
    step();
    gain_wr = 1'b0; gain_commit = 1'b0;
    check("coinc_kd0_old", 32'(kd0), 32'h0033);
    check("coinc_pend_kept", 32'(commit_pending[0]), 32'd1);
    check("coinc_se0", 32'(sample_en[0]), 32'd1);
    goto_phase(0);
    check("coinc_kd0_before_next", 32'(kd0), 32'h0033);
    step();
    check("coinc_kd0_new", 32'(kd0), 32'h0005);
    check("coinc_pend_clr", 32'(commit_pending[0]), 32'd0);

    // Reset pulse with a pending commit discards staging and pending
    goto_phase(10);
    write_gain(1'b1, 2'd0, 16'h0777);
    commit(1'b1);
    check("rst_pend_before", 32'(commit_pending), 32'h2);
    reset = 1'b1;
    step();
    check_reset_state("rst1");
    reset = 1'b0;
    base  = cyc;
    commit(1'b1);
    commit(1'b0);
    for (int k = 0; k < 2 * D; k++) step();
    check("rst_staging_kp1", 32'(kp1), 32'h0100);
    check("rst_staging_kp0", 32'(kp0), 32'h0100);
    check("rst_staging_pend", 32'(commit_pending), 32'd0);

    // Table of write/commit vectors with cumulative expected gains
    for (int r = 0; r < 8; r++) begin
      goto_phase(8);
      write_gain(tbl[r].ax, tbl[r].sel, tbl[r].data);
      if (tbl[r].commit) commit(tbl[r].ax);
      check($sformatf("tbl%0d_pend", r), 32'(commit_pending),
            32'(tbl[r].commit ? (tbl[r].ax ? 2'b10 : 2'b01) : 2'b00));
      for (int k = 0; k < 2 * D; k++) step();
      for (int i = 0; i < 6; i++)
        check($sformatf("tbl%0d_gain%0d", r, i), 32'(gains[i]), 32'(tbl[r].g[i]));
      check($sformatf("tbl%0d_pend_clr", r), 32'(commit_pending), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
